// File: rtl/traffic_frame_loader_if.sv
// rtl/traffic_frame_loader_if.sv - byte-serial frame stream handshake
interface traffic_frame_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/traffic_frame_loader.sv
// rtl/traffic_frame_loader.sv - frame loader, optional parity byte under FRAME_PARITY_EN
module traffic_frame_loader #(
  parameter  int FRAME_BYTES = 128,
  localparam int IMG_W       = 8 * FRAME_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  traffic_frame_loader_if.slave  src,
  output logic [IMG_W-1:0]       img_out,
  output logic [4:0]             load,
  output logic                   busy,
  output logic [7:0]             frame_cnt,
  output logic                   err_target,
  output logic                   err_parity,
  input  logic                   clr_err
);
  localparam int CW = $clog2(FRAME_BYTES + 1);
`ifdef FRAME_PARITY_EN
  localparam int DISC_LAST = FRAME_BYTES;
`else
  localparam int DISC_LAST = FRAME_BYTES - 1;
`endif

  typedef enum logic [2:0] {
    IDLE, RECV, DISCARD, LOAD
`ifdef FRAME_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state, nxt;
  logic             started;
  logic [2:0]       tgt;
  logic [CW-1:0]    cnt;
  logic [IMG_W-1:0] shreg;
  logic [IMG_W-1:0] img_q;
  logic             accept;
  logic             last_data;
  logic             bad_tgt;
`ifdef FRAME_PARITY_EN
  logic [7:0]       xacc;
`endif

  assign accept    = src.in_valid && src.in_ready;
  assign last_data = (cnt == CW'(FRAME_BYTES - 1));
  assign bad_tgt   = (src.in_data[2:0] > 3'd4);

  // in_ready stays low until the first edge after reset release
  assign src.in_ready = started && (state != LOAD);
  assign busy         = (state != IDLE);
  assign load         = (state == LOAD) ? (5'd1 << tgt) : 5'd0;
  // the completed frame is visible on img_out during the LOAD cycle itself
  assign img_out      = (state == LOAD) ? shreg : img_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = bad_tgt ? DISCARD : RECV;
`ifdef FRAME_PARITY_EN
      RECV:    if (accept && last_data) nxt = PARITY;
      PARITY:  if (accept) nxt = (src.in_data == xacc) ? LOAD : IDLE;
`else
      RECV:    if (accept && last_data) nxt = LOAD;
`endif
      DISCARD: if (accept && cnt == CW'(DISC_LAST)) nxt = IDLE;
      LOAD:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      tgt        <= 3'd0;
      cnt        <= '0;
      shreg      <= '0;
      img_q      <= '0;
      frame_cnt  <= 8'd0;
      err_target <= 1'b0;
      err_parity <= 1'b0;
`ifdef FRAME_PARITY_EN
      xacc       <= 8'd0;
`endif
    end else begin
      started <= 1'b1;
      if (state == IDLE && accept && bad_tgt) err_target <= 1'b1;
      else if (clr_err)                       err_target <= 1'b0;
`ifdef FRAME_PARITY_EN
      if (state == PARITY && accept && src.in_data != xacc) err_parity <= 1'b1;
      else if (clr_err)                                     err_parity <= 1'b0;
`else
      err_parity <= 1'b0;
`endif
      if (state == IDLE && accept) begin
        tgt <= src.in_data[2:0];
        cnt <= '0;
`ifdef FRAME_PARITY_EN
        xacc <= 8'd0;
`endif
      end
      if (state == RECV && accept) begin
        shreg <= {shreg[IMG_W-9:0], src.in_data};
        cnt   <= cnt + 1'b1;
`ifdef FRAME_PARITY_EN
        xacc  <= xacc ^ src.in_data;
`endif
      end
      if (state == DISCARD && accept) cnt <= cnt + 1'b1;
      if (nxt == LOAD && state != LOAD) frame_cnt <= frame_cnt + 8'd1;
      if (state == LOAD) img_q <= shreg;
    end
  end
endmodule

// File: tb/tb_traffic_frame_loader.sv
// tb/tb_traffic_frame_loader.sv - scoreboard bench for traffic_frame_loader
module tb_traffic_frame_loader;
  localparam int FB    = 128;
  localparam int IMG_W = 8 * FB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_err = 1'b0;
  logic [IMG_W-1:0] img_out;
  logic [4:0]       load;
  logic             busy;
  logic [7:0]       frame_cnt;
  logic             err_target, err_parity;

  traffic_frame_loader_if bus ();

  traffic_frame_loader #(.FRAME_BYTES(FB)) dut (
    .clk(clk), .rst_n(rst_n), .src(bus), .img_out(img_out), .load(load),
    .busy(busy), .frame_cnt(frame_cnt), .err_target(err_target),
    .err_parity(err_parity), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       load;
    logic [IMG_W-1:0] img;
    logic [7:0]       cnt;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  logic [7:0]       fb[FB];
  logic [IMG_W-1:0] model_img = '0;
  logic [7:0]       exp_cnt = 8'd0;
  logic             exp_et = 1'b0, exp_ep = 1'b0;
  int               checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask

  function automatic int diff_byte(input logic [IMG_W-1:0] a, input logic [IMG_W-1:0] b);
    for (int i = 0; i < FB; i++)
      if (a[IMG_W-1-8*i -: 8] !== b[IMG_W-1-8*i -: 8]) return i;
    return -1;
  endfunction

  // monitor: every load is matched against the oldest expected load
  always @(negedge clk) begin
    if (rst_n) begin
      if (|load) begin
        exp_t e;
        checks++;
        if (!$onehot(load)) begin
          errors++; $display("FAIL load_onehot got %b", load);
        end else if (sb.size() == 0) begin
          errors++; $display("FAIL unexpected_load got %b expected none", load);
        end else begin
          int d;
          e = sb.pop_front();
          d = diff_byte(img_out, e.img);
          if (load !== e.load) begin
            errors++; $display("FAIL load_bits got %b expected %b", load, e.load);
          end
          if (d >= 0) begin
            errors++;
            $display("FAIL img_out byte %0d got %h expected %h", d,
                     img_out[IMG_W-1-8*d -: 8], e.img[IMG_W-1-8*d -: 8]);
          end
          if (frame_cnt !== e.cnt) begin
            errors++; $display("FAIL frame_cnt got %0d expected %0d", frame_cnt, e.cnt);
          end
          if (cyc != e.cyc) begin
            errors++; $display("FAIL load_latency got cycle %0d expected %0d", cyc, e.cyc);
          end
          model_img = e.img;
        end
      end else begin
        int d;
        checks++;
        d = diff_byte(img_out, model_img);
        if (d >= 0) begin
          errors++;
          $display("FAIL img_stable byte %0d got %h expected %h", d,
                   img_out[IMG_W-1-8*d -: 8], model_img[IMG_W-1-8*d -: 8]);
        end
      end
    end
  end

  task automatic put_byte(input logic [7:0] b, input int gap);
    int n = 0;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got 0 expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // gmode: 0 back-to-back, 1 toggle valid each cycle, 2 sparse random gaps
  function automatic int gap_of(input int gmode);
    if (gmode == 1) return 1;
    if (gmode == 2) return ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 4)) : 0;
    return 0;
  endfunction

  task automatic send_frame(input logic [7:0] h, input int gmode, input bit clr, input bit bad_par);
    logic [IMG_W-1:0] img = '0;
    logic [7:0]       x = 8'd0;
    exp_t             e;
    bit               bad_t = (h[2:0] > 3'd4);
    if (clr) clr_err = 1'b1;
    put_byte(h, gap_of(gmode));
    clr_err = 1'b0;
    if (clr) begin exp_et = bad_t; exp_ep = 1'b0; end
    else if (bad_t) exp_et = 1'b1;
    for (int i = 0; i < FB; i++) begin
      img[IMG_W-1-8*i -: 8] = fb[i];
      x ^= fb[i];
      put_byte(fb[i], gap_of(gmode));
    end
`ifdef FRAME_PARITY_EN
    put_byte(x ^ {7'd0, bad_par}, gap_of(gmode));
    if (!bad_t && bad_par) exp_ep = 1'b1;
    if (!bad_t && !bad_par) begin
`else
    if (!bad_t) begin
`endif
      exp_cnt = exp_cnt + 8'd1;
      e.load = 5'd1 << h[2:0];
      e.img  = img;
      e.cnt  = exp_cnt;
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; clr_err = 1'b0;
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_img_nonzero", 32'(|img_out), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_err_target", 32'(err_target), 0);
    chk("rst_err_parity", 32'(err_parity), 0);
    sb.delete(); model_img = '0; exp_cnt = 8'd0; exp_et = 1'b0; exp_ep = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(bus.in_ready), 1);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic chk_flags(input string n);
    chk({n, "_err_target"}, 32'(err_target), 32'(exp_et));
    chk({n, "_err_parity"}, 32'(err_parity), 32'(exp_ep));
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
  endtask

  initial begin
    bus.in_data = 8'd0; bus.in_valid = 1'b0;
    do_reset();

    for (int i = 0; i < FB; i++) fb[i] = 8'(i);
    send_frame(8'h01, 0, 0, 0);
    drain();
    chk("first_frame_cnt", 32'(frame_cnt), 1);
    chk("first_img_top", 32'(img_out[IMG_W-1 -: 8]), 32'h00);
    chk("first_img_low", 32'(img_out[7:0]), 32'h7F);
    chk_flags("first");

    for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
    send_frame(8'h06, 0, 0, 0);
    chk_flags("discard");
    send_frame(8'h04, 2, 0, 0);
    drain();

    for (int i = 0; i < FB; i++) fb[i] = 8'(i);
    send_frame(8'hF8, 1, 0, 0);
    drain();
    chk("toggle_img_low", 32'(img_out[7:0]), 32'h7F);

    send_frame(8'h07, 0, 1, 0);
    chk_flags("set_wins");
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    exp_et = 1'b0; exp_ep = 1'b0;
    chk_flags("clear");

    put_byte(8'h02, 0);
    for (int i = 0; i < 60; i++) put_byte(8'($urandom), 0);
    do_reset();
    for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
    send_frame(8'h02, 0, 0, 0);
    drain();
    chk("post_reset_cnt", 32'(frame_cnt), 1);

    do_reset();
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
      send_frame({5'($urandom), 3'($urandom_range(0, 4))}, 2, 0, 0);
    end
    drain();
    chk("frame_cnt_wrap", 32'(frame_cnt), 0);
    chk_flags("wrap");

`ifdef FRAME_PARITY_EN
    for (int i = 0; i < FB; i++) fb[i] = 8'hA5;
    send_frame(8'h00, 0, 0, 0);
    drain();
    chk_flags("parity_ok");
    send_frame(8'h03, 0, 0, 1);
    drain();
    chk_flags("parity_bad");
    chk("parity_bad_cnt", 32'(frame_cnt), 32'(exp_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_frame_loader.md
TRAFFIC_FRAME_LOADER -- requirements
Module: traffic_frame_loader

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 128, number of image bytes per frame.
REQ-002 SHALL have derived parameter IMG_W, fixed at 8*FRAME_BYTES (1024 by default), image word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  8  byte-serial frame stream.
REQ-006 SHALL have port in_valid  input  1  in_data holds a valid byte.
REQ-007 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-008 SHALL have port img_out  output  IMG_W  last completed image frame.
REQ-009 SHALL have port load  output  5  one-hot load strobe: bit0 Mid, bit1 L, bit2 R, bit3 T, bit4 D.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port frame_cnt  output  8  count of frames delivered.
REQ-012 SHALL have port err_target  output  1  sticky error flag: bad target code.
REQ-013 SHALL have port err_parity  output  1  sticky error flag: parity mismatch.
REQ-014 SHALL have port clr_err  input  1  clears both sticky error flags.

Function
REQ-015 SHALL transfer a byte only on a rising clk edge where in_valid and in_ready are both 1.
REQ-016 SHALL define a frame as: 1 header byte, then FRAME_BYTES data bytes, then (only under macro) 1 parity byte.
REQ-017 SHALL implement the states IDLE, RECV, PARITY, DISCARD and LOAD.
REQ-018 SHALL drive in_ready=1 in IDLE, RECV, PARITY and DISCARD, and in_ready=0 in LOAD.
REQ-019 SHALL, in IDLE, take header[2:0] as the target: 0..4 goes to RECV; 5..7 goes to DISCARD and sets err_target; header[7:3] are ignored.
REQ-020 SHALL, in RECV, shift data MSB-first, so the first data byte lands in bits [IMG_W-1:IMG_W-8] and the last in [7:0].
REQ-021 SHALL use a byte counter of width ceil(log2(FRAME_BYTES+1)), reset to 0 at each header acceptance.
REQ-022 SHALL, after the last data byte, go to LOAD (or to PARITY under macro).
REQ-023 SHALL hold LOAD for exactly one cycle, during which: load[target]=1; img_out takes the shift register value in that same cycle; frame_cnt increments (255 wraps to 0); then return to IDLE.
REQ-024 SHALL, in DISCARD, consume exactly the remaining frame length with no load and no img_out change, then return to IDLE.
REQ-025 SHALL assert load[target] on the cycle immediately after the final data (or parity) byte is accepted.
REQ-026 SHALL hold img_out stable between loads; a partially received frame never appears on img_out.
REQ-027 SHALL, when clr_err and an error set occur in the same cycle, let the set win.
REQ-028 SHALL tolerate in_valid gaps of any length mid-frame without timeout; the state is held.
REQ-029 SHALL drive at most one load bit high in any cycle.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force: state IDLE, in_ready=0, img_out=0, load=0, busy=0, frame_cnt=0, err_target=0, err_parity=0, byte counter=0, shift register=0.
REQ-031 SHALL raise in_ready on the first rising edge after rst_n deasserts.
REQ-032 SHALL discard any partial frame on a mid-frame reset; the next byte after reset is treated as a header.

Configuration
REQ-033 SHALL, when macro FRAME_PARITY_EN is defined, expect a parity byte equal to the XOR of all FRAME_BYTES data bytes.
REQ-034 SHALL, under FRAME_PARITY_EN, go from PARITY to LOAD on a match; on a mismatch, set err_parity and return to IDLE with no load and no frame_cnt change.
REQ-035 SHALL, without FRAME_PARITY_EN, omit the PARITY state and parity logic, tie err_parity to 0, and make frames header+FRAME_BYTES long.

Verification
REQ-036 SHALL cover: reset, then header 0x01 + 128 bytes 0x00..0x7F back-to-back -> load=5'b00010 for one cycle; img_out[1023:1016]=0x00, img_out[7:0]=0x7F; frame_cnt=1.
REQ-037 SHALL cover: header 0x06 + 128 bytes -> err_target=1; no load; img_out unchanged; next header 0x04 frame -> load=5'b10000.
REQ-038 SHALL cover: in_valid toggled 1/0 every cycle through a Mid frame -> identical img_out to the back-to-back case; load asserted one cycle after the last accepted byte.
REQ-039 SHALL cover: rst_n pulsed low after 60 data bytes -> all outputs 0; a following full frame with header 0x02 -> load=5'b00100, correct data.
REQ-040 SHALL cover: 256 consecutive valid frames -> frame_cnt wraps to 0; clr_err asserted with no concurrent error -> both flags 0 next cycle.
REQ-041 SHALL cover, under FRAME_PARITY_EN: data all 0xA5, parity byte 0x00 -> load; parity byte 0x01 -> err_parity=1, no load, frame_cnt unchanged.
